// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencing controller for the CPU datapath.
// Optional macro MUL_STALL_EN: MUL holds EXEC for MUL_CYCLES cycles and drives mul_busy.
module multicycle_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] op,
  input  logic       zero,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_load,
  output logic       dmem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       byte_en,
  output logic       mem_reg,
  output logic       alu_src,
  output logic [3:0] alu_ctrl,
  output logic       reg_write,
  output logic [2:0] pc_sel,
  output logic       pc_write,
  output logic       illegal,
  output logic       mul_busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_LBD  = 5'd10;
  localparam logic [4:0] OP_LDW  = 5'd11;
  localparam logic [4:0] OP_STB  = 5'd12;
  localparam logic [4:0] OP_STW  = 5'd13;
  localparam logic [4:0] OP_MOV  = 5'd14;
  localparam logic [4:0] OP_BEQ  = 5'd30;
  localparam logic [4:0] OP_JUMP = 5'd31;

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
    $error("MUL_CYCLES must be in 1..15");
  end

  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       illegal_q, illegal_d;
`ifdef MUL_STALL_EN
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
  logic [3:0] mul_cnt_q, mul_cnt_d;
`endif

  function automatic logic op_legal(input logic [4:0] o);
    case (o)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4,
      OP_LBD, OP_LDW, OP_STB, OP_STW, OP_MOV,
      OP_BEQ, OP_JUMP: op_legal = 1'b1;
      default:         op_legal = 1'b0;
    endcase
  endfunction

  logic is_rtype, is_load, is_store, is_mov, is_beq;
  logic ex_alu_src;
  logic [3:0] ex_alu_ctrl;

  always_comb begin
    is_rtype    = (op_q <= OP_OR);
    is_load     = (op_q == OP_LBD) || (op_q == OP_LDW);
    is_store    = (op_q == OP_STB) || (op_q == OP_STW);
    is_mov      = (op_q == OP_MOV);
    is_beq      = (op_q == OP_BEQ);
    ex_alu_src  = is_load || is_store || is_mov;
    ex_alu_ctrl = '0;
    if (is_rtype)    ex_alu_ctrl = op_q[3:0];
    else if (is_beq) ex_alu_ctrl = 4'd1;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
`ifdef MUL_STALL_EN
    mul_cnt_d = mul_cnt_q;
`endif
    case (state_q)
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        op_d = op;
        // Flag is set on TRAP entry so it is already high in the first TRAP cycle.
        if (!op_legal(op)) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else if (op == OP_JUMP) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq)                    state_d = S_FETCH;
        else if (is_load || is_store)  state_d = S_MEM;
`ifdef MUL_STALL_EN
        else if (op_q == OP_MUL && mul_cnt_q != MUL_LAST) mul_cnt_d = mul_cnt_q + 4'd1;
        else begin
          mul_cnt_d = '0;
          state_d   = S_WB;
        end
`else
        else                           state_d = S_WB;
`endif
      end
      S_MEM:  if (dmem_ack) state_d = is_load ? S_WB : S_FETCH;
      S_WB:   state_d = S_FETCH;
      S_TRAP: illegal_d = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
`ifdef MUL_STALL_EN
      mul_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
`ifdef MUL_STALL_EN
      mul_cnt_q <= mul_cnt_d;
`endif
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    byte_en   = 1'b0;
    mem_reg   = 1'b0;
    alu_src   = 1'b0;
    alu_ctrl  = '0;
    reg_write = 1'b0;
    pc_sel    = '0;
    pc_write  = 1'b0;
    illegal   = 1'b0;
    mul_busy  = 1'b0;
    state     = '0;
    if (!rst) begin
      illegal = illegal_q;
      state   = state_q;
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (op == OP_JUMP) begin
            pc_sel   = 3'd2;
            pc_write = 1'b1;
          end
        end
        S_EXEC: begin
          alu_src  = ex_alu_src;
          alu_ctrl = ex_alu_ctrl;
          if (is_beq) begin
            pc_sel   = 3'd1;
            pc_write = zero;
          end
`ifdef MUL_STALL_EN
          mul_busy = (op_q == OP_MUL) && (mul_cnt_q != MUL_LAST);
`endif
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          mem_read  = is_load;
          mem_write = is_store;
          byte_en   = (op_q == OP_LBD) || (op_q == OP_STB);
        end
        S_WB: begin
          reg_write = 1'b1;
          mem_reg   = is_load;
          alu_src   = ex_alu_src;
          alu_ctrl  = ex_alu_ctrl;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the CPU datapath. Steps each instruction through the FETCH, DECODE, EXEC, MEM and WB states.
- Generates the same control strobes as the single-cycle opcode decoder (alu_ctrl, mem_read, mem_write, mem_reg, alu_src, reg_write, PC select), one state per cycle.
- Handshakes with the instruction and data memories, stalling until each returns an ack.
- Sits between the instruction register and the datapath muxes/register file.

Parameters:
- MUL_CYCLES, 4: EXEC cycles spent on MUL when MUL_STALL_EN is defined; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- op  in  5  opcode field from the instruction register; valid from DECODE onward
- zero  in  1  ALU zero flag; sampled in EXEC for BEQ
- imem_ack  in  1  instruction memory done; IR data valid this cycle
- dmem_ack  in  1  data memory done; load data valid this cycle
- imem_req  out  1  instruction fetch request
- ir_load  out  1  load instruction register
- dmem_req  out  1  data memory request
- mem_read  out  1  data read
- mem_write  out  1  data write
- byte_en  out  1  1 = byte access (LBD/STB), 0 = word access
- mem_reg  out  1  writeback mux: 1 = memory data, 0 = ALU result
- alu_src  out  1  ALU B mux: 1 = immediate, 0 = register
- alu_ctrl  out  4  ADD=0, SUB=1, MUL=2, AND=3, OR=4
- reg_write  out  1  register file write strobe
- pc_sel  out  3  0 = PC+4, 1 = branch target, 2 = jump target
- pc_write  out  1  PC update strobe
- illegal  out  1  sticky illegal-opcode flag
- mul_busy  out  1  high while a MUL stall is in progress
- state  out  3  current state, for debug

Behaviour:
- Opcodes: ADD 0, SUB 1, MUL 2, AND 3, OR 4, LBD 10, LDW 11, STB 12, STW 13, MOV 14, BEQ 30, JUMP 31. Every other value is illegal.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5.
- Registered state: state, op_q (5 bits, captured in DECODE), illegal, mul_cnt. All outputs except illegal are combinational from state and op_q.
- Reset: on a clk edge with rst=1, state becomes FETCH, op_q=0, illegal=0, mul_cnt=0.
  - While rst=1, all outputs are forced to 0.
  - Reset in any state, including MEM mid-handshake, abandons the instruction; the first cycle after rst falls is FETCH.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_load=1, pc_write=1, pc_sel=0, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - op_q<=op.
  - Illegal op: next state TRAP.
  - JUMP: pc_sel=2, pc_write=1, next state FETCH (2 cycles plus fetch wait).
  - All other legal ops: next state EXEC.
- EXEC:
  - R-type: alu_src=0, alu_ctrl per opcode, next state WB.
  - Loads and stores: alu_src=1, alu_ctrl=0 (address calculation), next state MEM.
  - MOV: alu_src=1, alu_ctrl=0, next state WB.
  - BEQ: alu_ctrl=1; pc_sel=1 and pc_write=zero; next state FETCH.
- MEM:
  - dmem_req=1.
  - mem_read=1 for LBD/LDW; mem_write=1 for STB/STW.
  - byte_en=1 for LBD/STB.
  - Held until dmem_ack. On ack, loads go to WB and stores go to FETCH.
- WB:
  - reg_write=1 for one cycle.
  - mem_reg=1 for loads, 0 otherwise.
  - alu_ctrl and alu_src hold their EXEC values.
  - Next state FETCH.
- TRAP:
  - illegal<=1; all strobes 0.
  - Absorbing state; only rst leaves it.
- Acks:
  - An ack received in a state that does not request it is ignored.
  - An ack held high for several cycles advances the FSM one transition only.
- Unused outputs are 0 in every state.
- Cycle counts with zero-wait acks: R-type/MOV 4, load 5, store 4, BEQ 3, JUMP 2.

Optional Feature:
- Macro: MUL_STALL_EN.
- Defined:
  - MUL holds EXEC for exactly MUL_CYCLES cycles; mul_cnt counts up from 0 on EXEC entry.
  - mul_busy=1 during every MUL EXEC cycle except the last.
  - alu_ctrl=2 is held throughout; WB follows.
  - A reset during the stall clears mul_cnt.
- Undefined:
  - MUL is single-cycle like ADD.
  - mul_busy is tied to 0, mul_cnt is absent and MUL_CYCLES is ignored.

Test Plan:
- Reset, op=0 (ADD), imem_ack pulsed the cycle after rst falls -> state sequence 0,1,2,4,0; reg_write=1 only in WB; alu_ctrl=0; pc_write=1 once in FETCH.
- op=11 (LDW), dmem_ack delayed 3 cycles -> MEM held 4 cycles with dmem_req=mem_read=1 and byte_en=0; WB has mem_reg=1 and reg_write=1.
- op=30 (BEQ) with zero=1, then with zero=0 -> EXEC pc_sel=1 and pc_write=1/0; no reg_write; returns to FETCH.
- op=7 (illegal) -> TRAP next cycle; illegal=1 sticky over 20 cycles; rst clears it and state returns to FETCH.
- With MUL_STALL_EN and MUL_CYCLES=4, op=2 -> EXEC lasts 4 cycles; mul_busy=1 for 3 cycles; alu_ctrl=2 throughout. Without the macro -> EXEC lasts 1 cycle and mul_busy=0.
- op=13 (STW) with rst asserted mid-MEM -> all outputs 0 next cycle; FETCH with imem_req=1 after rst falls; no mem_write after reset.
